alu_writeback: RTL and testbench
================================

// Module: alu_writeback
// PURPOSE
//   Consumer end of the ALU result interface (R, S, ALU_Exception) in the execute->writeback path.
//   Accepts one ALU result per handshake and writes it to the register file: R goes to the
//   destination register. For MUL/DIV, S (upper product / remainder) goes to HI_REG_ADDR in a
//   second write cycle. ALU exceptions are turned into a held request to the control unit.
// PARAMETERS
//   DATA_WIDTH      16     width of R, S, RF_Data
//   CTRL_WIDTH      4      width of ALU_Ctrl
//   REG_ADDR_WIDTH  4      register-file address width
//   HI_REG_ADDR     0      register that receives S for MUL/DIV
//   COUNT_WIDTH     16     width of Op_Count
// PORTS
//   clk            in   1               single clock, rising edge
//   reset_n        in   1               asynchronous, active-low reset
//   In_Valid       in   1               execute stage presents a result
//   In_Ready       out  1               block can accept (state IDLE)
//   ALU_Ctrl       in   CTRL_WIDTH      function code of the presented result
//   R              in   DATA_WIDTH      ALU lower result
//   S              in   DATA_WIDTH      ALU upper result / remainder
//   ALU_Exception  in   1               ALU flagged overflow, divide-by-0 or invalid code
//   Dest_Addr      in   REG_ADDR_WIDTH  destination register for R
//   RF_WE          out  1               register-file write enable
//   RF_Addr        out  REG_ADDR_WIDTH  register-file write address
//   RF_Data        out  DATA_WIDTH      register-file write data
//   Exc_Req        out  1               exception request to control unit, held until acked
//   Exc_Code       out  CTRL_WIDTH      ALU_Ctrl of the faulting operation
//   Exc_Ack        in   1               control unit acknowledges Exc_Req
//   Op_Count       out  COUNT_WIDTH     number of retired (written) operations, wraps
// BEHAVIOUR
//   - Reset (reset_n=0, async): state IDLE; RF_WE, RF_Addr, RF_Data, Exc_Req, Exc_Code and Op_Count
//     are all 0; In_Ready=1 once reset deasserts. Reset mid-operation drops any pending write or
//     exception.
//   - All outputs are registered except In_Ready = (state==IDLE).
//   - Accept = In_Valid & In_Ready, sampled at a rising edge. R, S, ALU_Ctrl, Dest_Addr and
//     ALU_Exception are captured only on accept.
//   - FSM states: IDLE, WR_LO, WR_HI, EXC_WAIT.
//     IDLE: on accept with ALU_Exception=1 -> EXC_WAIT, regardless of code.
//           on accept with ALU_Ctrl=0 (NOP) and no exception -> stay IDLE. No write, no count.
//           on any other accept -> WR_LO.
//     WR_LO: RF_WE=1, RF_Addr=Dest_Addr, RF_Data=R, for exactly one cycle.
//           -> WR_HI if code is MUL(4'b0001) or DIV(4'b0010), else -> IDLE.
//     WR_HI: RF_WE=1, RF_Addr=HI_REG_ADDR, RF_Data=S, for one cycle -> IDLE.
//     EXC_WAIT: Exc_Req=1, Exc_Code=captured code. No RF write. The state holds until Exc_Ack=1
//           is sampled while Exc_Req=1, then -> IDLE, and Exc_Req clears the same edge.
//   - Latency: with accept at edge T, the lo write is visible in cycle T+1 and the hi write in
//     cycle T+2. Throughput: one op per 2 cycles (single write) or 3 cycles (MUL/DIV).
//   - RF_Addr and RF_Data return to 0 whenever RF_WE=0.
//   - Exc_Ack outside EXC_WAIT is ignored. In_Valid while not ready is ignored; the producer
//     must hold its data.
//   - If Dest_Addr==HI_REG_ADDR on MUL/DIV, both writes occur and S is the final value.
//   - Op_Count increments by 1 on the last write of each op: leaving WR_LO to IDLE, or leaving
//     WR_HI. It wraps from all-ones to 0. NOPs and exceptions do not count.
// STRUCTURE
//   - Shared include alu_defs.vh: function-code constants (ADD, SUB, AND, OR, MUL, DIV, SLL, SLR,
//     ROL, ROR, NOP=0), DATA_WIDTH/CTRL_WIDTH defaults, FSM state encodings. The ALU and this
//     block both use it.
//   - One FSM plus capture registers and the counter live in this module; no sub-module is
//     needed.
// TESTING
//   1. ADD: R=16'h0005, Dest_Addr=3 -> one cycle RF_WE=1, RF_Addr=3, RF_Data=5; Op_Count 0->1.
//   2. MUL: R=16'h0000, S=16'h0001, Dest=2 -> cycle T+1 writes reg2=0, cycle T+2 writes
//      reg0=1; In_Ready low for 2 cycles.
//   3. DIV by 0 with ALU_Exception=1, ALU_Ctrl=4'b0010 -> no RF_WE; Exc_Req=1, Exc_Code=2 held
//      10 cycles. Exc_Ack pulse -> Exc_Req=0 and In_Ready=1 next cycle.
//   4. NOP (ALU_Ctrl=0) accepted -> no RF_WE, Op_Count unchanged, In_Ready stays 1.
//   5. Assert reset_n=0 during WR_HI of a DIV -> RF_WE drops immediately, all outputs 0, no
//      hi write after release.
//   6. Preload Op_Count to 16'hFFFF with back-to-back ADDs held valid -> count wraps to 0, and
//      each accept occurs only when In_Ready=1.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU result interface: function codes,
// default widths and the writeback FSM state encodings.
package alu_writeback_pkg;

  // ALU function codes (4-bit). NOP must stay 0.
  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_MUL = 4'h1;
  localparam logic [3:0] ALU_DIV = 4'h2;
  localparam logic [3:0] ALU_ADD = 4'h3;
  localparam logic [3:0] ALU_SUB = 4'h4;
  localparam logic [3:0] ALU_AND = 4'h5;
  localparam logic [3:0] ALU_OR  = 4'h6;
  localparam logic [3:0] ALU_SLL = 4'h7;
  localparam logic [3:0] ALU_SLR = 4'h8;
  localparam logic [3:0] ALU_ROL = 4'h9;
  localparam logic [3:0] ALU_ROR = 4'hA;

  // Default widths shared by the ALU and the writeback block.
  localparam int ALU_DATA_WIDTH = 16;
  localparam int ALU_CTRL_WIDTH = 4;

  // Writeback FSM state encodings.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WR_LO    = 2'd1;
  localparam logic [1:0] ST_WR_HI    = 2'd2;
  localparam logic [1:0] ST_EXC_WAIT = 2'd3;

endpackage

// File: rtl/alu_writeback.sv
// Writeback end of the execute stage: takes one ALU result per handshake,
// writes R (and S for MUL/DIV) to the register file, and raises a held
// exception request for faulting operations.
//
// Handshake: a result is accepted at a rising edge where In_Valid and
// In_Ready are both 1. In_Ready is high only in IDLE; the producer must hold
// its data while In_Valid is high and In_Ready is low. Exc_Req is held until
// Exc_Ack is sampled high while Exc_Req is high.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_WIDTH     = ALU_DATA_WIDTH,
  parameter int CTRL_WIDTH     = ALU_CTRL_WIDTH,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int HI_REG_ADDR    = 0,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      In_Valid,
  output logic                      In_Ready,
  input  logic [CTRL_WIDTH-1:0]     ALU_Ctrl,
  input  logic [DATA_WIDTH-1:0]     R,
  input  logic [DATA_WIDTH-1:0]     S,
  input  logic                      ALU_Exception,
  input  logic [REG_ADDR_WIDTH-1:0] Dest_Addr,
  output logic                      RF_WE,
  output logic [REG_ADDR_WIDTH-1:0] RF_Addr,
  output logic [DATA_WIDTH-1:0]     RF_Data,
  output logic                      Exc_Req,
  output logic [CTRL_WIDTH-1:0]     Exc_Code,
  input  logic                      Exc_Ack,
  output logic [COUNT_WIDTH-1:0]    Op_Count,
  output logic [1:0]                Dbg_State
);

  localparam logic [REG_ADDR_WIDTH-1:0] HI_ADDR  = REG_ADDR_WIDTH'(HI_REG_ADDR);
  localparam logic [CTRL_WIDTH-1:0]     CODE_NOP = CTRL_WIDTH'(ALU_NOP);
  localparam logic [CTRL_WIDTH-1:0]     CODE_MUL = CTRL_WIDTH'(ALU_MUL);
  localparam logic [CTRL_WIDTH-1:0]     CODE_DIV = CTRL_WIDTH'(ALU_DIV);

  logic [1:0]                state_q, state_d;
  logic [CTRL_WIDTH-1:0]     code_q, code_d;
  logic [DATA_WIDTH-1:0]     s_q, s_d;
  logic                      rf_we_q, rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]     rf_data_q, rf_data_d;
  logic                      exc_req_q, exc_req_d;
  logic [CTRL_WIDTH-1:0]     exc_code_q, exc_code_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic                      accept;
  logic                      code_is_wide;

  assign In_Ready     = (state_q == ST_IDLE);
  assign accept       = In_Valid & In_Ready;
  assign code_is_wide = (code_q == CODE_MUL) || (code_q == CODE_DIV);

  // Next-state and registered-output logic; write outputs are computed one
  // cycle ahead so RF_* are driven straight from flops in WR_LO / WR_HI.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    s_d        = s_q;
    rf_we_d    = 1'b0;
    rf_addr_d  = '0;
    rf_data_d  = '0;
    exc_req_d  = exc_req_q;
    exc_code_d = exc_code_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          code_d = ALU_Ctrl;
          s_d    = S;
          if (ALU_Exception) begin
            state_d    = ST_EXC_WAIT;
            exc_req_d  = 1'b1;
            exc_code_d = ALU_Ctrl;
          end else if (ALU_Ctrl != CODE_NOP) begin
            state_d   = ST_WR_LO;
            rf_we_d   = 1'b1;
            rf_addr_d = Dest_Addr;
            rf_data_d = R;
          end
        end
      end
      ST_WR_LO: begin
        if (code_is_wide) begin
          state_d   = ST_WR_HI;
          rf_we_d   = 1'b1;
          rf_addr_d = HI_ADDR;
          rf_data_d = s_q;
        end else begin
          state_d = ST_IDLE;
          count_d = count_q + COUNT_WIDTH'(1);
        end
      end
      ST_WR_HI: begin
        state_d = ST_IDLE;
        count_d = count_q + COUNT_WIDTH'(1);
      end
      ST_EXC_WAIT: begin
        if (Exc_Ack && exc_req_q) begin
          state_d    = ST_IDLE;
          exc_req_d  = 1'b0;
          exc_code_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, capture, output and counter registers with async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      s_q        <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      exc_req_q  <= 1'b0;
      exc_code_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      s_q        <= s_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      exc_req_q  <= exc_req_d;
      exc_code_q <= exc_code_d;
      count_q    <= count_d;
    end
  end

  assign RF_WE     = rf_we_q;
  assign RF_Addr   = rf_addr_q;
  assign RF_Data   = rf_data_q;
  assign Exc_Req   = exc_req_q;
  assign Exc_Code  = exc_code_q;
  assign Op_Count  = count_q;
  assign Dbg_State = state_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: a table of single operations plus
// hand-written exception, reset and back-to-back sequences.
module tb_alu_writeback;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int AW = 4;
  // Narrow counter so the wrap from all-ones to 0 is reachable quickly.
  localparam int NW = 4;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] alu_ctrl;
  logic [DW-1:0] r_in;
  logic [DW-1:0] s_in;
  logic          alu_exc;
  logic [AW-1:0] dest_addr;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          exc_req;
  logic [CW-1:0] exc_code;
  logic          exc_ack;
  logic [NW-1:0] op_count;
  logic [1:0]    dbg_state;

  int checks;
  int failures;
  int exp_count;

  alu_writeback #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .REG_ADDR_WIDTH(AW),
    .HI_REG_ADDR(0), .COUNT_WIDTH(NW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .In_Valid(in_valid), .In_Ready(in_ready),
    .ALU_Ctrl(alu_ctrl), .R(r_in), .S(s_in), .ALU_Exception(alu_exc),
    .Dest_Addr(dest_addr),
    .RF_WE(rf_we), .RF_Addr(rf_addr), .RF_Data(rf_data),
    .Exc_Req(exc_req), .Exc_Code(exc_code), .Exc_Ack(exc_ack),
    .Op_Count(op_count), .Dbg_State(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] r;
    logic [DW-1:0] s;
    logic [AW-1:0] dest;
    int            nwr;      // number of RF writes expected (0, 1, 2)
    logic [DW-1:0] hi_data;  // expected data of the write to reg 0
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_we"}, 32'(rf_we), 32'd0);
    chk({tag, "_addr"}, 32'(rf_addr), 32'd0);
    chk({tag, "_data"}, 32'(rf_data), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    alu_ctrl  = v.ctrl;
    r_in      = v.r;
    s_in      = v.s;
    dest_addr = v.dest;
    alu_exc   = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    r_in      = 16'hDEAD;
    s_in      = 16'hBEEF;
    if (v.nwr == 0) begin
      check_idle_outputs({v.name, "_nowr"});
      chk({v.name, "_ready"}, 32'(in_ready), 32'd1);
    end else begin
      chk({v.name, "_lo_we"}, 32'(rf_we), 32'd1);
      chk({v.name, "_lo_addr"}, 32'(rf_addr), 32'(v.dest));
      chk({v.name, "_lo_data"}, 32'(rf_data), 32'(v.r));
      chk({v.name, "_lo_ready"}, 32'(in_ready), 32'd0);
      if (v.nwr == 2) begin
        @(negedge clk);
        chk({v.name, "_hi_we"}, 32'(rf_we), 32'd1);
        chk({v.name, "_hi_addr"}, 32'(rf_addr), 32'd0);
        chk({v.name, "_hi_data"}, 32'(rf_data), 32'(v.hi_data));
        chk({v.name, "_hi_ready"}, 32'(in_ready), 32'd0);
      end
      exp_count = (exp_count + 1) % (1 << NW);
    end
    @(negedge clk);
    check_idle_outputs({v.name, "_after"});
    chk({v.name, "_after_ready"}, 32'(in_ready), 32'd1);
    chk({v.name, "_count"}, 32'(op_count), 32'(exp_count));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_count = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = '0;
    r_in      = '0;
    s_in      = '0;
    alu_exc   = 1'b0;
    dest_addr = '0;
    exc_ack   = 1'b0;

    vecs[0] = '{"add",   4'h3, 16'h0005, 16'h0000, 4'd3,  1, 16'h0000};
    vecs[1] = '{"mul",   4'h1, 16'h0000, 16'h0001, 4'd2,  2, 16'h0001};
    vecs[2] = '{"nop",   4'h0, 16'h1111, 16'h2222, 4'd5,  0, 16'h0000};
    vecs[3] = '{"sub",   4'h4, 16'hABCD, 16'h5555, 4'd15, 1, 16'h0000};
    vecs[4] = '{"div_r0",4'h2, 16'h0007, 16'h0003, 4'd0,  2, 16'h0003};
    vecs[5] = '{"or",    4'h6, 16'hFFFF, 16'h1234, 4'd9,  1, 16'h0000};

    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    chk("rst_exc_req", 32'(exc_req), 32'd0);
    chk("rst_exc_code", 32'(exc_code), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Exc_Ack while idle has no effect
    exc_ack = 1'b1;
    @(negedge clk);
    exc_ack = 1'b0;
    chk("stray_ack_ready", 32'(in_ready), 32'd1);
    chk("stray_ack_req", 32'(exc_req), 32'd0);

    // Table of single operations
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // DIV by zero with exception: request held for 10 cycles, then acked
    alu_ctrl = 4'h2; r_in = 16'h0; s_in = 16'h0; dest_addr = 4'd4;
    alu_exc  = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; alu_exc = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("exc_req_held", 32'(exc_req), 32'd1);
      chk("exc_code_held", 32'(exc_code), 32'd2);
      chk("exc_no_we", 32'(rf_we), 32'd0);
      chk("exc_not_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("exc_state", 32'(dbg_state), 32'd3);
    exc_ack = 1'b1;
    @(negedge clk);
    exc_ack = 1'b0;
    chk("exc_ack_req", 32'(exc_req), 32'd0);
    chk("exc_ack_ready", 32'(in_ready), 32'd1);
    chk("exc_count", 32'(op_count), 32'(exp_count));

    // Exception with NOP code still goes to the exception wait
    alu_ctrl = 4'h0; alu_exc = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; alu_exc = 1'b0;
    chk("excnop_req", 32'(exc_req), 32'd1);
    chk("excnop_code", 32'(exc_code), 32'd0);
    exc_ack = 1'b1;
    @(negedge clk);
    exc_ack = 1'b0;
    chk("excnop_ack_req", 32'(exc_req), 32'd0);

    // Reset during the hi write of a DIV
    alu_ctrl = 4'h2; r_in = 16'h0009; s_in = 16'h0004; dest_addr = 4'd6;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstdiv_lo_we", 32'(rf_we), 32'd1);
    @(negedge clk);
    chk("rstdiv_hi_we", 32'(rf_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("rstdiv");
    chk("rstdiv_count", 32'(op_count), 32'd0);
    exp_count = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle_outputs("rstdiv_post");
    end
    chk("rstdiv_post_count", 32'(op_count), 32'd0);

    // Back-to-back ADDs held valid: one accept every 2 cycles, count wraps
    alu_ctrl = 4'h3; r_in = 16'h0001; s_in = 16'h0; dest_addr = 4'd1;
    in_valid = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      chk("b2b_we", 32'(rf_we), 32'((c % 2) == 0));
      chk("b2b_ready", 32'(in_ready), 32'((c % 2) == 1));
      chk("b2b_count", 32'(op_count), 32'(((c + 1) / 2) % 16));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_wrap_count", 32'(op_count), 32'd0);
    check_idle_outputs("b2b_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
